// File: rtl/ex_div_ctrl.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per clock,
// returns {remainder, quotient} for the HI/LO write and stalls EX while busy.
module ex_div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_start_i,
    input  logic                div_signed_i,
    input  logic                div_annul_i,
    input  logic [DATA_W-1:0]   div_oprd1_i,
    input  logic [DATA_W-1:0]   div_oprd2_i,
    output logic [2*DATA_W-1:0] div_result_o,
    output logic                div_ready_o,
    output logic                stallreq_o,
    output logic [1:0]          dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    localparam logic [1:0] S_FREE    = 2'd0;
    localparam logic [1:0] S_BY_ZERO = 2'd1;
    localparam logic [1:0] S_ON      = 2'd2;
    localparam logic [1:0] S_END     = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd;    // dividend shifts out MSB-first, quotient bits shift in
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] rem;
    logic              neg_q;
    logic              neg_r;

    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W-1:0] rem_sub;
    logic              q_bit;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    always_comb begin
        a_neg     = div_signed_i & div_oprd1_i[DATA_W-1];
        b_neg     = div_signed_i & div_oprd2_i[DATA_W-1];
        abs_a     = a_neg ? -div_oprd1_i : div_oprd1_i;
        abs_b     = b_neg ? -div_oprd2_i : div_oprd2_i;
        rem_shift = {rem, dvd[DATA_W-1]};
        q_bit     = rem_shift >= {1'b0, dvs};
        // When q_bit is set the true difference is below dvs, so DATA_W bits suffice.
        rem_sub   = rem_shift[DATA_W-1:0] - dvs;
        rem_next  = q_bit ? rem_sub : rem_shift[DATA_W-1:0];
        quot_fix  = neg_q ? -dvd : dvd;
        rem_fix   = neg_r ? -rem : rem;
    end

    // Handshake: ex holds div_start_i high until it sees div_ready_o; the result is
    // consumed in the one cycle where both are high, and ready falls the edge after start does.
    assign stallreq_o  = div_start_i & ~div_annul_i & ~div_ready_o;
    assign dbg_state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FREE;
            cnt          <= '0;
            dvd          <= '0;
            dvs          <= '0;
            rem          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_result_o <= '0;
            div_ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    div_ready_o <= 1'b0;
                    if (div_start_i && !div_annul_i) begin
                        if (div_oprd2_i == '0) begin
                            state <= S_BY_ZERO;
                        end else begin
                            state <= S_ON;
                            dvd   <= abs_a;
                            dvs   <= abs_b;
                            rem   <= '0;
                            cnt   <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                S_BY_ZERO: begin
                    state        <= S_END;
                    div_result_o <= '0;
                    div_ready_o  <= 1'b1;
                end
                S_ON: begin
                    if (!div_start_i || div_annul_i) begin
                        state <= S_FREE;
                    end else if (cnt != CNT_LAST) begin
                        rem <= rem_next;
                        dvd <= {dvd[DATA_W-2:0], q_bit};
                        cnt <= cnt + 1'b1;
                    end else begin
                        div_result_o <= {rem_fix, quot_fix};
                        div_ready_o  <= 1'b1;
                        state        <= S_END;
                    end
                end
                S_END: begin
                    // No relaunch until start has dropped at least once.
                    if (!div_start_i || div_annul_i) begin
                        state       <= S_FREE;
                        div_ready_o <= 1'b0;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: vector table plus sequences for annul, reset, END hold
// and back-to-back requests; expected results flow through a queue.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start_i;
    logic        div_signed_i;
    logic        div_annul_i;
    logic [31:0] div_oprd1_i;
    logic [31:0] div_oprd2_i;
    logic [63:0] div_result_o;
    logic        div_ready_o;
    logic        stallreq_o;
    logic [1:0]  dbg_state_o;

    localparam logic [1:0] ST_FREE = 2'd0;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    ex_div_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_start_i  (div_start_i),
        .div_signed_i (div_signed_i),
        .div_annul_i  (div_annul_i),
        .div_oprd1_i  (div_oprd1_i),
        .div_oprd2_i  (div_oprd2_i),
        .div_result_o (div_result_o),
        .div_ready_o  (div_ready_o),
        .stallreq_o   (stallreq_o),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = a;
        sb = b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // driver: called at a falling edge, leaves start held
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        div_signed_i = sgn;
        div_oprd1_i  = a;
        div_oprd2_i  = b;
        div_start_i  = 1'b1;
        exp_q.push_back(exp);
        #1;
    endtask

    // waits for ready, scoreboards the result, optionally holds start in END, then drops start
    task automatic complete_run(input int exp_lat, input int hold_extra);
        int cyc;
        int stall_cyc;
        logic [63:0] exp;
        cyc = 0;
        stall_cyc = stallreq_o ? 1 : 0;
        while (!div_ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                div_oprd1_i = $urandom;
                div_oprd2_i = $urandom;
            end
            if (!div_ready_o && stallreq_o) stall_cyc++;
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        check("stall_cycles", 64'(stall_cyc), 64'(exp_lat));
        check("stall_at_ready", {63'd0, stallreq_o}, 64'd0);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check("result", div_result_o, exp);
        for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            check("hold_ready", {63'd0, div_ready_o}, 64'd1);
            check("hold_result", div_result_o, exp);
        end
        div_start_i = 1'b0;
        @(negedge clk);
        check("ready_drop", {63'd0, div_ready_o}, 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        logic        seen_ready;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'h0000_000E}};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD}};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF}};
        vecs[4]  = '{1'b1, 32'd5,          32'd0,          64'd0};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF,  32'd3}};
        vecs[7]  = '{1'b0, 32'd7,          32'hFFFF_FFF9,  {32'd7,          32'd0}};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0,          32'd1}};
        vecs[9]  = '{1'b0, 32'd0,          32'd5,          64'd0};
        vecs[10] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          {32'd1,          32'h7FFF_FFFC}};

        rst          = 1'b1;
        div_start_i  = 1'b0;
        div_signed_i = 1'b0;
        div_annul_i  = 1'b0;
        div_oprd1_i  = '0;
        div_oprd2_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, div_ready_o}, 64'd0);
        check("rst_result", div_result_o, 64'd0);
        check("rst_state", {62'd0, dbg_state_o}, {62'd0, ST_FREE});
        rst = 1'b0;

        // annul overrides start while idle
        div_start_i = 1'b1;
        div_annul_i = 1'b1;
        div_oprd2_i = 32'd3;
        #1;
        check("annul_idle_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        check("annul_idle_state", {62'd0, dbg_state_o}, {62'd0, ST_FREE});
        div_start_i = 1'b0;
        div_annul_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
            complete_run((vecs[i].b == 32'd0) ? 2 : 34, 0);
        end

        for (int i = 0; i < 6; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            launch(sgn, a, b, model(sgn, a, b));
            complete_run((b == 32'd0) ? 2 : 34, 0);
        end

        // annul at cycle 10 of ON
        div_signed_i = 1'b0;
        div_oprd1_i  = 32'd1000;
        div_oprd2_i  = 32'd3;
        div_start_i  = 1'b1;
        repeat (10) @(negedge clk);
        div_annul_i = 1'b1;
        #1;
        check("annul_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        check("annul_state", {62'd0, dbg_state_o}, {62'd0, ST_FREE});
        div_start_i = 1'b0;
        div_annul_i = 1'b0;
        seen_ready  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (div_ready_o) seen_ready = 1'b1;
        end
        check("annul_no_ready", {63'd0, seen_ready}, 64'd0);
        launch(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
        complete_run(34, 0);

        // reset at cycle 5 of ON, start held through and after it
        launch(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", {62'd0, dbg_state_o}, {62'd0, ST_FREE});
        check("midrst_result", div_result_o, 64'd0);
        check("midrst_ready", {63'd0, div_ready_o}, 64'd0);
        rst = 1'b0;
        #1;
        complete_run(34, 0);

        // start held in END, then back-to-back with one idle cycle
        launch(1'b0, 32'd100, 32'd7, {32'd2, 32'h0000_000E});
        complete_run(34, 3);
        launch(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
        complete_run(34, 0);
        launch(1'b1, 32'd5, 32'd0, 64'd0);
        complete_run(2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
